// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone front-end of the sky130 2 KB SRAM macro pair.
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam int BANK_BIT  = 11;
  localparam int WORD_LSB  = 2;
  localparam int NUM_BANKS = 2;

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving port 0 of two SRAM macros with registered controls;
// absorbs the macro read latency and returns a single-cycle ack.
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 32,
  parameter int          SEL_W     = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [SEL_W-1:0]     wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [DATA_W-1:0]    wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [DATA_W-1:0]    wbs_dat_o,
  output logic [NUM_BANKS-1:0] ram_csb0_o,
  output logic                 ram_web0_o,
  output logic [SEL_W-1:0]     ram_wmask0_o,
  output logic [ADDR_W-1:0]    ram_addr0_o,
  output logic [DATA_W-1:0]    ram_din0_o,
  input  logic [DATA_W-1:0]    ram_dout0_b0_i,
  input  logic [DATA_W-1:0]    ram_dout0_b1_i
);

  state_t state;
  logic   bank_q;
  logic   we_q;
  logic   hit;

  assign hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      bank_q       <= 1'b0;
      we_q         <= 1'b0;
      ram_csb0_o   <= '1;
      ram_web0_o   <= 1'b1;
      ram_wmask0_o <= '0;
      ram_addr0_o  <= '0;
      ram_din0_o   <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            ram_addr0_o  <= wbs_adr_i[WORD_LSB +: ADDR_W];
            ram_din0_o   <= wbs_dat_i;
            bank_q       <= wbs_adr_i[BANK_BIT];
            we_q         <= wbs_we_i;
            ram_web0_o   <= ~wbs_we_i;
            ram_wmask0_o <= wbs_we_i ? wbs_sel_i : '0;
            ram_csb0_o   <= ~(NUM_BANKS'(1) << wbs_adr_i[BANK_BIT]);
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // Macro samples its controls on this edge; release them right away.
          ram_csb0_o   <= '1;
          ram_web0_o   <= 1'b1;
          ram_wmask0_o <= '0;
          if (we_q) begin
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          wbs_dat_o <= bank_q ? ram_dout0_b1_i : ram_dout0_b0_i;
          wbs_ack_o <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
Wishbone classic slave that fronts the two sky130_sram_2kbyte_1rw1r_32x512_8 macros and drives their port 0 (rw) with registered controls.
- Decodes a 4 KB window into two 2 KB banks.
- Generates active-low chip-select and write-enable, and generates the byte mask.
- Absorbs the macro's one-cycle read latency and returns a single-cycle ack.
- Sits between the Caravel Wishbone bus and the SRAM macros in user_project_wrapper. Port 1 (r) of both macros is unused: the wrapper ties csb1 high.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base; must be 4 KB aligned.
- ADDR_MASK, 32'hFFFF_F000, bits compared against BASE_ADDR for a hit.
- ADDR_W, 9, macro word-address width.
- DATA_W, 32, data width.
- SEL_W, 4, byte lanes (DATA_W/8).

Ports:
- wb_clk_i  in  1  single clock, rising edge; also drives macro clk0.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  SEL_W  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  DATA_W  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  DATA_W  read data.
- ram_csb0_o  out  2  per-bank chip select, active-low; bit b = bank b.
- ram_web0_o  out  1  write enable, active-low, shared by both banks.
- ram_wmask0_o  out  SEL_W  byte write mask, shared.
- ram_addr0_o  out  ADDR_W  word address, shared.
- ram_din0_o  out  DATA_W  write data, shared.
- ram_dout0_b0_i  in  DATA_W  bank 0 read data.
- ram_dout0_b1_i  in  DATA_W  bank 1 read data.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ram_csb0_o=2'b11, ram_web0_o=1, ram_wmask0_o=0, ram_addr0_o=0, ram_din0_o=0.
  - wbs_ack_o=0, wbs_dat_o=0.
- Hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR).
- Address split: word = wbs_adr_i[10:2] and bank = wbs_adr_i[11]. Bits [1:0] are ignored.
- States: IDLE, ACCESS, RDWAIT, ACK. All outputs are registered.
- IDLE:
  - On hit, latch word→ram_addr0_o, dat_i→ram_din0_o, bank, we.
  - ram_web0_o = ~we. ram_wmask0_o = we ? sel : 0.
  - ram_csb0_o[bank]=0, other bank stays 1. Go to ACCESS.
  - Non-hit: stay in IDLE, outputs unchanged (csb stays high).
- ACCESS (exactly 1 cycle): the macro samples its controls at the rising edge ending this cycle.
  - On that edge: ram_csb0_o←2'b11, ram_web0_o←1, ram_wmask0_o←0.
  - Write: go to ACK, wbs_ack_o←1.
  - Read: go to RDWAIT.
- RDWAIT: the selected bank's dout is valid.
  - At the cycle end: wbs_dat_o←(bank ? ram_dout0_b1_i : ram_dout0_b0_i), wbs_ack_o←1, go to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, then wbs_ack_o←0 and go to IDLE.
  - A back-to-back hit is only accepted from IDLE, so there is at least one idle cycle between transfers.
- Latency, counted from the first cycle a hit is presented in IDLE (cycle 0):
  - write ack high in cycle 2.
  - read ack high in cycle 3.
- wbs_dat_o holds the last read value until the next read. Writes leave it unchanged.
- A write with sel=0 still pulses csb with wmask=0 and is acked: no bytes change.
- Master abort (cyc_i low in ACCESS/RDWAIT/ACK): the macro access still completes. If cyc_i is low during ACK, wbs_ack_o is still driven for that one cycle; masters ignore ack without cyc.
- wbs_stb_i/adr/dat changes after IDLE are ignored; the latched copies are used.
- Reset mid-operation: return to IDLE immediately and deassert csb. The macro access in flight may or may not complete; it is not acked.

Decomposition:
- Package wb_sram_pkg holds:
  - state enum (IDLE, ACCESS, RDWAIT, ACK).
  - localparams BANK_BIT=11, WORD_LSB=2, NUM_BANKS=2.
- Single module, no sub-module; the read mux is inline.

Test Plan:
- Write bank 0: adr=32'h3000_0010, dat=32'hDEAD_BEEF, sel=4'hF.
  → cycle 1: csb=2'b10, web=0, addr=9'h004, wmask=4'hF.
  → cycle 2: ack=1 for one cycle.
- Read back bank 0 from 32'h3000_0010 (memory model returns DEAD_BEEF).
  → cycle 1: csb=2'b10, web=1, wmask=0.
  → cycle 3: ack=1, dat_o=32'hDEAD_BEEF.
- Bank select: write 32'h1234_5678 to 32'h3000_0810.
  → csb=2'b01, addr=9'h004.
  → a read of 32'h3000_0010 still returns DEAD_BEEF; a read of 32'h3000_0810 returns 1234_5678.
- Byte mask: write 32'hAABB_CCDD, sel=4'b0101, to a word holding 0.
  → wmask=4'b0101; readback 32'h00BB_00DD.
- Miss: adr=32'h3000_1000 and adr=32'h2000_0000.
  → csb stays 2'b11 and ack stays 0 for 10 cycles.
- Reset during ACCESS: drive wb_rst_ni low asynchronously.
  → csb=2'b11, ack=0, dat_o=0 immediately.
  → after release, a new read of 32'h3000_0000 acks in cycle 3.
